dot_matrix_scanner: RTL and testbench
=====================================

// Module: dot_matrix_scanner
// PURPOSE
//  Parametrised column-scan driver for LED dot-matrix panels. Successor to the fixed 16x16 scanner.
//  Pattern comes from a double-buffered frame memory written by the host, not from a hard-wired table.
//  Sits between the display-content logic (host write port) and the panel row/column pins.
//  Column strobe and row data update in the same clock, so the panel never sees a mismatched pair.
// PARAMETERS
//  ROWS       16    bits per column word (panel height)
//  COLS       16    columns scanned per frame; power of two, >= 2
//  PRESCALE   2400  clocks per column dwell; >= BLANK_CYC+2
//  BLANK_CYC  4     clocks at the start of each dwell with rows forced off (ghost suppression)
//  ACTIVE_LOW 1     1: a lit dot drives 0 on dot_r; 0: a lit dot drives 1
//  COL_W      derived localparam $clog2(COLS), not overridable
// PORTS
//  clock        in   1      system clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  wr_en        in   1      write one column word into the back bank
//  wr_addr      in   COL_W  column index of the write
//  wr_data      in   ROWS   column pattern; 1 = dot lit (logical, independent of ACTIVE_LOW)
//  swap_req     in   1      request a bank swap at the next frame boundary
//  swap_done    out  1      1-clock pulse when the swap takes effect
//  frame_start  out  1      1-clock pulse coincident with dot_c going to 0
//  dot_r        out  ROWS   row drive, polarity per ACTIVE_LOW
//  dot_c        out  COL_W  active column index
// BEHAVIOUR
//  - Reset: prescaler=0, column=0, dot_c=0, dot_r=OFF (all 1 if ACTIVE_LOW, else all 0).
//    Reset also clears swap_done, frame_start, pending swap, display bank select (=0) and both banks (all dots off).
//  - Prescaler counts 0..PRESCALE-1, then wraps. tick = (prescaler==PRESCALE-1).
//  - On tick, column advances col+1; COLS-1 wraps to 0.
//  - dot_c and dot_r are registered and change on the clock after the tick edge, together.
//  - Latency from a column change to its valid data: 0 clocks between dot_c and dot_r.
//  - Blanking: for prescaler < BLANK_CYC, dot_r = OFF.
//    Otherwise dot_r = polarity(display_bank[read_col]).
//  - Frame boundary = tick while col==COLS-1. frame_start pulses on the cycle dot_c becomes 0.
//  - Double buffer: writes always go to the back bank (!sel); the display bank (sel) is read-only to the scan.
//  - swap_req sets the pending flag; repeated requests while pending merge into one.
//  - At a frame boundary with pending set: sel toggles, pending clears, and swap_done pulses
//    in the same cycle as frame_start. The new bank is shown from column 0 of the next frame.
//  - Simultaneous events:
//    * wr_en on the swap cycle writes the pre-swap back bank.
//    * swap_req on a frame-boundary cycle with pending clear is honoured at that boundary (same cycle).
//  - Reset mid-frame: everything returns to reset values immediately. The next frame starts cleanly from column 0.
//  - wr_addr >= COLS is impossible (COLS is a power of two).
// CONFIGURATION
//  DOT_MATRIX_SCROLL_EN defined:
//   - adds input scroll_off [COL_W-1:0].
//   - scroll_off is sampled into scroll_q only at frame boundaries; reset value 0.
//   - read_col = (col + scroll_q) mod COLS, giving horizontal wrap-around scrolling.
//  DOT_MATRIX_SCROLL_EN undefined:
//   - port is absent and read_col = col.
//   - no scroll logic is synthesised.
// STRUCTURE
//  - Package dot_matrix_pkg:
//    * function to_drive(pattern, ACTIVE_LOW) for polarity conversion.
//    * OFF pattern constant helper.
//    * clog2 helper.
//  - Sub-module dot_scan_timer: prescaler plus column counter.
//    * Outputs tick, col, blank, frame_end.
//  - Top level holds the two banks, bank select/pending logic, scroll and the output registers.
// TESTING (ROWS=16, COLS=16, PRESCALE=8, BLANK_CYC=2, ACTIVE_LOW=1)
//  1 Reset release, no writes -> dot_r=16'hFFFF throughout;
//    dot_c steps 0..15 every 8 clocks; frame_start every 128 clocks.
//  2 Write col3=16'h00FF to back bank, pulse swap_req mid-frame ->
//    swap_done coincides with the next frame_start; in the col 3 dwell, dot_r=FFFF for 2 clocks, then 16'hFF00.
//  3 Before swap, display still unchanged -> all columns read FFFF until swap_done;
//    no partial frame containing new data.
//  4 swap_req asserted 3 times in one frame -> exactly one swap_done; sel toggles once.
//  5 wr_en col5=16'h8001 on the swap_done cycle -> data lands in the new back bank;
//    it appears only after a second swap.
//  6 Assert rst while dot_c=9 -> dot_c=0, dot_r=FFFF and pending cleared asynchronously;
//    banks read FFFF after a subsequent swap.
//  7 (DOT_MATRIX_SCROLL_EN) col0=16'h0001, others off, scroll_off=2 ->
//    from the next frame the lit word shows at dot_c=14 (reads col 0).

Source files
------------

// File: rtl/dot_matrix_pkg.sv
// Shared types and helpers for the dot-matrix column scanner.
// Row words are carried internally at MAX_ROWS bits so the polarity helpers
// can serve any panel height up to that limit.
package dot_matrix_pkg;

  // Widest panel the polarity helpers support.
  localparam int unsigned MAX_ROWS = 64;

  typedef logic [MAX_ROWS-1:0] row_word_t;

  // Frame-boundary events, delayed one stage so they line up with the output registers.
  typedef struct packed {
    logic frame;
    logic swap;
  } scan_evt_t;

  // Logical pattern (1 = lit) to pin levels.
  function automatic row_word_t to_drive(input row_word_t pattern, input bit active_low);
    return active_low ? ~pattern : pattern;
  endfunction

  // Pin levels with every dot dark.
  function automatic row_word_t off_pattern(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/dot_scan_timer.sv
// Column-dwell prescaler and column counter for the dot-matrix scanner.
// tick marks the last clock of a dwell; frame_end marks the last clock of a frame.
module dot_scan_timer
  import dot_matrix_pkg::*;
#(
  parameter int unsigned COLS      = 16,
  parameter int unsigned PRESCALE  = 2400,
  parameter int unsigned BLANK_CYC = 4,
  localparam int unsigned COL_W    = clog2(COLS)
) (
  input  logic             clock,
  input  logic             rst,
  output logic             tick,
  output logic [COL_W-1:0] col,
  output logic             blank,
  output logic             frame_end
);

  localparam int unsigned PRE_W = clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] BLANK_LIM = PRE_W'(BLANK_CYC);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [COL_W-1:0] col_q, col_d;

  assign tick      = (pre_q == PRE_MAX);
  assign blank     = (pre_q < BLANK_LIM);
  assign col       = col_q;
  assign frame_end = tick && (col_q == COL_MAX);

  // Next-state: prescaler wraps on tick; column wraps naturally as COLS is a power of two.
  always_comb begin
    pre_d = pre_q + 1'b1;
    col_d = col_q;
    if (tick) begin
      pre_d = '0;
      col_d = col_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      col_q <= '0;
    end else begin
      pre_q <= pre_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Column-scan driver for LED dot-matrix panels with a double-buffered frame store.
// The host writes the back bank; the scan reads the display bank; a requested swap
// happens only at a frame boundary so no frame ever mixes old and new content.
// dot_c and dot_r come from the same register stage, so they always change together.
// Optional build macro: DOT_MATRIX_SCROLL_EN adds scroll_off for horizontal wrap scrolling.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COLS       = 16,
  parameter int unsigned PRESCALE   = 2400,
  parameter int unsigned BLANK_CYC  = 4,
  parameter int unsigned ACTIVE_LOW = 1,
  localparam int unsigned COL_W     = clog2(COLS)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [ROWS-1:0]  wr_data,
  input  logic             swap_req,
`ifdef DOT_MATRIX_SCROLL_EN
  input  logic [COL_W-1:0] scroll_off,
`endif
  output logic             swap_done,
  output logic             frame_start,
  output logic [ROWS-1:0]  dot_r,
  output logic [COL_W-1:0] dot_c
);

  localparam logic [ROWS-1:0] OFF = ROWS'(off_pattern(ACTIVE_LOW != 0));

  logic             tick;
  logic [COL_W-1:0] col;
  logic             blank;
  logic             frame_end;

  logic [ROWS-1:0]  bank0_q [COLS];
  logic [ROWS-1:0]  bank1_q [COLS];
  logic             sel_q, sel_d;
  logic             pending_q, pending_d;
  logic             swap_take;
  logic [COL_W-1:0] read_col;
  logic [ROWS-1:0]  disp_word;
  logic [ROWS-1:0]  drive_word;
  logic [ROWS-1:0]  dot_r_d;
  scan_evt_t        evt_q, evt_d;
  logic             unused_tick;

  assign unused_tick = tick;

  dot_scan_timer #(
    .COLS      (COLS),
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clock     (clock),
    .rst       (rst),
    .tick      (tick),
    .col       (col),
    .blank     (blank),
    .frame_end (frame_end)
  );

  // Host writes land in the back bank; sel picks which bank is on display.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (sel_q) begin
        bank0_q[wr_addr] <= wr_data;
      end else begin
        bank1_q[wr_addr] <= wr_data;
      end
    end
  end

  // A request on the boundary cycle itself is honoured at that same boundary.
  assign swap_take = frame_end && (pending_q || swap_req);

  // Swap bookkeeping: requests merge while pending; the boundary consumes them.
  always_comb begin
    pending_d = pending_q | swap_req;
    sel_d     = sel_q;
    if (frame_end) begin
      pending_d = 1'b0;
    end
    if (swap_take) begin
      sel_d = ~sel_q;
    end
  end

  // Bank select and pending flag.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      pending_q <= pending_d;
    end
  end

`ifdef DOT_MATRIX_SCROLL_EN
  logic [COL_W-1:0] scroll_q;

  // Offset only changes between frames so a frame never tears mid-scan.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      scroll_q <= '0;
    end else if (frame_end) begin
      scroll_q <= scroll_off;
    end
  end

  assign read_col = col + scroll_q;
`else
  assign read_col = col;
`endif

  assign disp_word  = sel_q ? bank1_q[read_col] : bank0_q[read_col];
  assign drive_word = ROWS'(to_drive(row_word_t'(disp_word), ACTIVE_LOW != 0));

  // Row drive for the current counter state; dark during the start-of-dwell blanking.
  always_comb begin
    dot_r_d = drive_word;
    if (blank) begin
      dot_r_d = OFF;
    end
  end

  // Boundary events wait one stage so the pulses land on the clock where dot_c shows 0.
  always_comb begin
    evt_d.frame = frame_end;
    evt_d.swap  = swap_take;
  end

  // Output registers: column, rows and event pulses all update on the same edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      evt_q       <= '0;
      dot_c       <= '0;
      dot_r       <= OFF;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      evt_q       <= evt_d;
      dot_c       <= col;
      dot_r       <= dot_r_d;
      frame_start <= evt_q.frame;
      swap_done   <= evt_q.swap;
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner (ROWS=16, COLS=16, PRESCALE=8, BLANK_CYC=2,
// ACTIVE_LOW=1). Each clock an expected output word is pushed to a scoreboard queue and
// popped/compared at the following falling edge. Scroll scenario runs only when
// DOT_MATRIX_SCROLL_EN is defined.
`define CHECK_CYCLE(TAG) \
  begin \
    e = sb.pop_front(); \
    n_cmp++; \
    if (dot_c !== e.c || dot_r !== e.r || frame_start !== e.fs || swap_done !== e.sd) begin \
      n_bad++; \
      $display("FAIL %s cyc=%0d got c=%0d r=%h fs=%b sd=%b required c=%0d r=%h fs=%b sd=%b", \
               TAG, cyc, dot_c, dot_r, frame_start, swap_done, e.c, e.r, e.fs, e.sd); \
    end \
  end

module tb_dot_matrix_scanner;

  localparam int FRAME = 128;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_done, frame_start;
  logic [15:0] dot_r;
  logic [3:0]  dot_c;
`ifdef DOT_MATRIX_SCROLL_EN
  logic [3:0]  scroll_off = '0;
`endif

  typedef struct packed {
    logic [3:0]  c;
    logic [15:0] r;
    logic        fs;
    logic        sd;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;      // rising edges since reset release
  int          swap_at = -1; // cycle on which swap_done is expected
  int          m_sel = 0;
  int          m_scroll = 0;
  int          scroll_drv = 0;
  logic [15:0] m_bank [2][16];

  always #5 clock = ~clock;

  dot_matrix_scanner #(
    .ROWS       (16),
    .COLS       (16),
    .PRESCALE   (8),
    .BLANK_CYC  (2),
    .ACTIVE_LOW (1)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
`ifdef DOT_MATRIX_SCROLL_EN
    .scroll_off  (scroll_off),
`endif
    .swap_done   (swap_done),
    .frame_start (frame_start),
    .dot_r       (dot_r),
    .dot_c       (dot_c)
  );

  // One clock: advance, push the expected outputs for this cycle, land on the falling edge.
  task automatic cycle();
    exp_t x;
    int   c, p, rc;
    @(posedge clock);
    cyc++;
    if (cyc == swap_at) m_sel ^= 1;
    if (cyc > 1 && (cyc - 1) % FRAME == 0) m_scroll = scroll_drv;
    c    = ((cyc - 1) / DWELL) % 16;
    p    = (cyc - 1) % DWELL;
    rc   = (c + m_scroll) % 16;
    x.c  = 4'(c);
    x.r  = (p < BLANK) ? 16'hFFFF : ~m_bank[m_sel][rc];
    x.fs = (cyc > 1 && (cyc - 1) % FRAME == 0);
    x.sd = (cyc == swap_at);
    sb.push_back(x);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    wr_en    = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic drive_write(input int addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    m_bank[(m_sel == 0) ? 1 : 0][addr] = data;
  endtask

  // Swap takes effect at the first boundary edge at or after the sampling edge.
  task automatic drive_swap();
    int e0;
    swap_req = 1'b1;
    e0 = cyc + 1;
    if (!(swap_at > cyc)) swap_at = ((e0 + FRAME - 1) / FRAME) * FRAME + 1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clock);
    @(negedge clock);
    rst      = 1'b0;
    cyc      = 0;
    swap_at  = -1;
    m_sel    = 0;
    m_scroll = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) m_bank[b][i] = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (dot_c !== 4'd0) begin n_bad++; $display("FAIL reset_dot_c got %0d required 0", dot_c); end
    n_cmp++;
    if (dot_r !== 16'hFFFF) begin n_bad++; $display("FAIL reset_dot_r got %h required ffff", dot_r); end
    n_cmp++;
    if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b required 0", frame_start); end
    n_cmp++;
    if (swap_done !== 1'b0) begin n_bad++; $display("FAIL reset_sd got %b required 0", swap_done); end
  endtask

  // Blank display: FFFF throughout, column steps every 8 clocks, frame_start every 128.
  task automatic test_scan();
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cycle();
      `CHECK_CYCLE("scan")
    end
  endtask

  // Write col3 then swap mid-frame; nothing new may show before swap_done.
  task automatic test_swap();
    int early_lit = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 5) drive_write(3, 16'h00FF);
      if (i == 60) drive_swap();
      cycle();
      clear_inputs();
      `CHECK_CYCLE("swap")
      if (i > 60 && cyc < swap_at && dot_r !== 16'hFFFF) early_lit++;
      if (i > 60 && cyc == swap_at) begin
        n_cmp++;
        if (frame_start !== 1'b1 || dot_c !== 4'd0) begin
          n_bad++;
          $display("FAIL swap_align got fs=%b c=%0d required fs=1 c=0", frame_start, dot_c);
        end
      end
      if (i > 60 && cyc == swap_at + 24) begin
        n_cmp++;
        if (dot_c !== 4'd3 || dot_r !== 16'hFFFF) begin
          n_bad++;
          $display("FAIL col3_blank got c=%0d r=%h required c=3 r=ffff", dot_c, dot_r);
        end
      end
      if (i > 60 && cyc == swap_at + 26) begin
        n_cmp++;
        if (dot_c !== 4'd3 || dot_r !== 16'hFF00) begin
          n_bad++;
          $display("FAIL col3_data got c=%0d r=%h required c=3 r=ff00", dot_c, dot_r);
        end
      end
      if (i > 60 && cyc >= swap_at + FRAME + 2) break;
    end
    n_cmp++;
    if (early_lit !== 0) begin
      n_bad++;
      $display("FAIL pre_swap_dark got %0d lit cycles required 0", early_lit);
    end
  endtask

  // Three requests in one frame must merge into a single swap.
  task automatic test_multi_swap();
    int n_sd = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 10 || i == 30 || i == 50) drive_swap();
      cycle();
      clear_inputs();
      `CHECK_CYCLE("multi_swap")
      if (swap_done === 1'b1) n_sd++;
      if (i > 50 && cyc >= swap_at + FRAME + 2) break;
    end
    n_cmp++;
    if (n_sd !== 1) begin
      n_bad++;
      $display("FAIL multi_swap_count got %0d required 1", n_sd);
    end
  endtask

  // Write on the swap_done cycle lands in the new back bank; visible only after a second swap.
  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      if (i == 10) drive_swap();
      cycle();
      clear_inputs();
      `CHECK_CYCLE("b2b_first")
      if (i > 10 && cyc == swap_at) break;
    end
    drive_write(5, 16'h8001);
    for (int i = 0; i < 400; i++) begin
      if (i == 60) drive_swap();
      cycle();
      clear_inputs();
      `CHECK_CYCLE("b2b_second")
      if (i < 60 && cyc == swap_at + 42) begin
        n_cmp++;
        if (dot_c !== 4'd5 || dot_r !== 16'hFFFF) begin
          n_bad++;
          $display("FAIL col5_hidden got c=%0d r=%h required c=5 r=ffff", dot_c, dot_r);
        end
      end
      if (i > 60 && cyc == swap_at + 42) begin
        n_cmp++;
        if (dot_c !== 4'd5 || dot_r !== 16'h7FFE) begin
          n_bad++;
          $display("FAIL col5_shown got c=%0d r=%h required c=5 r=7ffe", dot_c, dot_r);
        end
      end
      if (i > 60 && cyc >= swap_at + FRAME + 2) break;
    end
  endtask

  // Reset during column 9 with a swap pending; afterwards both banks must be dark.
  task automatic test_reset_mid();
    for (int i = 0; i < 200; i++) begin
      if (i == 0) drive_swap();
      cycle();
      clear_inputs();
      `CHECK_CYCLE("pre_reset")
      if (((cyc - 1) / DWELL) % 16 == 9 && (cyc - 1) % DWELL == 3) break;
    end
    n_cmp++;
    if (dot_c !== 4'd9) begin n_bad++; $display("FAIL mid_col got %0d required 9", dot_c); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dot_c !== 4'd0) begin n_bad++; $display("FAIL async_dot_c got %0d required 0", dot_c); end
    n_cmp++;
    if (dot_r !== 16'hFFFF) begin n_bad++; $display("FAIL async_dot_r got %h required ffff", dot_r); end
    apply_reset();
    for (int i = 0; i < FRAME + 4; i++) begin
      cycle();
      `CHECK_CYCLE("post_reset_nopend")
    end
    for (int i = 0; i < 400; i++) begin
      if (i == 3) drive_swap();
      cycle();
      clear_inputs();
      `CHECK_CYCLE("post_reset_swap")
      if (i > 3 && cyc >= swap_at + FRAME + 2) break;
    end
  endtask

`ifdef DOT_MATRIX_SCROLL_EN
  // Offset 2: column 0 content appears while dot_c is 14.
  task automatic test_scroll();
    scroll_drv = 2;
    scroll_off = 4'd2;
    for (int i = 0; i < 400; i++) begin
      if (i == 2) drive_write(0, 16'h0001);
      if (i == 5) drive_swap();
      cycle();
      clear_inputs();
      `CHECK_CYCLE("scroll")
      if (i > 5 && cyc == swap_at + 114) begin
        n_cmp++;
        if (dot_c !== 4'd14 || dot_r !== 16'hFFFE) begin
          n_bad++;
          $display("FAIL scroll_col14 got c=%0d r=%h required c=14 r=fffe", dot_c, dot_r);
        end
      end
      if (i > 5 && cyc >= swap_at + FRAME + 2) break;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_swap();
    test_multi_swap();
    test_back_to_back();
    test_reset_mid();
`ifdef DOT_MATRIX_SCROLL_EN
    test_scroll();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
